hamming_selftest_seq: RTL and testbench

Sequencer that exhaustively exercises the Hamming(7,4) encoder -> fault injector -> decoder datapath. It drives every 4-bit data word combined with every fault pattern: no fault, plus a single-bit flip at each codeword position 1..7. It compares the decoded nibble against the driven nibble and accumulates pass/fail statistics. It sits between the board-level controls and the datapath, replacing manual switch/button stimulus during bring-up.

---
 rtl/hamming_selftest_seq.sv | 108 ++++++++++
 tb/tb_hamming_selftest_seq.sv | 135 +++++++++++++
 2 files changed

// File: rtl/hamming_selftest_seq.sv
// Exhaustive self-test sequencer for a Hamming(7,4) encode -> fault inject -> decode path.
// Walks all 16 data nibbles x 8 fault patterns and tallies decoder pass/fail results.
module hamming_selftest_seq #(
  parameter int DECODE_LATENCY = 1,
  parameter int CNT_W          = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  output logic [3:0]       enc_data_o,
  output logic [2:0]       fault_sel_o,
  input  logic [3:0]       dec_data_i,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] pass_count,
  output logic [CNT_W-1:0] fail_count,
  output logic             fail_seen,
  output logic [3:0]       first_fail_data,
  output logic [2:0]       first_fail_fault
);

  typedef enum logic [1:0] {IDLE, APPLY, DONE} state_t;

  localparam logic [2:0] LAT = 3'(DECODE_LATENCY);

  state_t     state;
  logic [6:0] vec;
  logic [2:0] dwell;
  logic       match;

  // Fault index is the low field so it varies fastest across the sweep.
  assign enc_data_o  = vec[6:3];
  assign fault_sel_o = vec[2:0];
  assign match       = (dec_data_i == vec[6:3]);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    // NOTE: reset is synchronous and clears every register, counters included,
    // so a mid-run reset leaves no stale statistics behind.
    if (!rst_n) begin
      state            <= IDLE;
      vec              <= '0;
      dwell            <= '0;
      busy             <= 1'b0;
      done             <= 1'b0;
      pass_count       <= '0;
      fail_count       <= '0;
      fail_seen        <= 1'b0;
      first_fail_data  <= '0;
      first_fail_fault <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start && !abort) begin
            state            <= APPLY;
            busy             <= 1'b1;
            done             <= 1'b0;
            vec              <= '0;
            dwell            <= '0;
            pass_count       <= '0;
            fail_count       <= '0;
            fail_seen        <= 1'b0;
            first_fail_data  <= '0;
            first_fail_fault <= '0;
          end
        end

        APPLY: begin
          if (abort) begin
            // Partial statistics and the current vector are kept for inspection.
            state <= IDLE;
            busy  <= 1'b0;
          end else if (dwell != LAT) begin
            dwell <= dwell + 3'd1;
          end else begin
            if (match) begin
              pass_count <= pass_count + CNT_W'(1);
            end else begin
              fail_count <= fail_count + CNT_W'(1);
              if (!fail_seen) begin
                fail_seen        <= 1'b1;
                first_fail_data  <= vec[6:3];
                first_fail_fault <= vec[2:0];
              end
            end
            if (vec == 7'd127) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              vec   <= vec + 7'd1;
              dwell <= '0;
            end
          end
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hamming_selftest_seq.sv
// Directed bench for hamming_selftest_seq: one instance with DECODE_LATENCY=1 (registered
// decoder model) and one with DECODE_LATENCY=0 (combinational decoder model), shared controls.
module tb_hamming_selftest_seq;

  logic clk = 1'b0;
  logic rst_n, start, abort;
  int   mode;  // 0 golden, 1 stuck at zero, 2 inverts data when fault_sel==5

  logic [3:0] enc1, dec1, ffd1, enc0, dec0, ffd0;
  logic [2:0] flt1, fff1, flt0, fff0;
  logic       busy1, done1, fs1, busy0, done0, fs0;
  logic [7:0] pass1, fail1, pass0, fail0;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  hamming_selftest_seq #(.DECODE_LATENCY(1), .CNT_W(8)) u_lat1 (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .enc_data_o(enc1), .fault_sel_o(flt1), .dec_data_i(dec1),
    .busy(busy1), .done(done1), .pass_count(pass1), .fail_count(fail1),
    .fail_seen(fs1), .first_fail_data(ffd1), .first_fail_fault(fff1)
  );

  hamming_selftest_seq #(.DECODE_LATENCY(0), .CNT_W(8)) u_lat0 (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .enc_data_o(enc0), .fault_sel_o(flt0), .dec_data_i(dec0),
    .busy(busy0), .done(done0), .pass_count(pass0), .fail_count(fail0),
    .fail_seen(fs0), .first_fail_data(ffd0), .first_fail_fault(fff0)
  );

  function automatic logic [3:0] model_dec(input int m, input logic [3:0] d, input logic [2:0] f);
    if (m == 1) return 4'h0;
    if (m == 2 && f == 3'd5) return ~d;
    return d;
  endfunction

  always @(posedge clk) dec1 <= model_dec(mode, enc1, flt1);
  always_comb dec0 = model_dec(mode, enc0, flt0);

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_lat1"}, {busy1, done1, fs1, ffd1, fff1, enc1, flt1, pass1, fail1}, 64'd0);
    check({tag, "_lat0"}, {busy0, done0, fs0, ffd0, fff0, enc0, flt0, pass0, fail0}, 64'd0);
  endtask

  // Full run from IDLE or DONE; checks both instances at completion.
  task automatic run(input string tag, input int m, input int ep, input int ef,
                     input logic efs, input logic [3:0] efd, input logic [2:0] eff);
    int  n1, n0;
    bit  finished;
    mode = m;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    check({tag, "_clr1"}, {busy1, pass1, fail1, fs1}, {1'b1, 8'd0, 8'd0, 1'b0});
    check({tag, "_clr0"}, {busy0, pass0, fail0, fs0}, {1'b1, 8'd0, 8'd0, 1'b0});
    n1 = 1; n0 = 1; finished = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (busy1) n1++;
      if (busy0) n0++;
      if (!busy1 && !busy0) begin finished = 1'b1; break; end
    end
    check({tag, "_timeout"}, finished, 1'b1);
    check({tag, "_busy1"}, n1, 256);
    check({tag, "_busy0"}, n0, 128);
    check({tag, "_res1"}, {done1, pass1, fail1, fs1, ffd1, fff1},
          {1'b1, 8'(ep), 8'(ef), efs, efd, eff});
    check({tag, "_res0"}, {done0, pass0, fail0, fs0, ffd0, fff0},
          {1'b1, 8'(ep), 8'(ef), efs, efd, eff});
    check({tag, "_last1"}, {enc1, flt1}, 7'd127);
  endtask

  // Wait (bounded) until the latency-1 instance presents vector v.
  task automatic wait_vec(input string tag, input logic [6:0] v);
    bit hit = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if ({enc1, flt1} == v) begin hit = 1'b1; break; end
    end
    check({tag, "_reach"}, hit, 1'b1);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; mode = 0;
    repeat (2) @(negedge clk);
    check_zero("reset");
    rst_n = 1'b1;

    run("golden",  0, 128, 0,   1'b0, 4'h0, 3'd0);
    run("stuck0",  1, 8,   120, 1'b1, 4'h1, 3'd0);
    run("fault5",  2, 112, 16,  1'b1, 4'h0, 3'd5);

    // Abort while vector 40 is presented, before its compare edge.
    mode = 0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    wait_vec("abort", 7'd40);
    abort = 1'b1;
    @(negedge clk); abort = 1'b0;
    check("abort_state", {busy1, done1}, 2'b00);
    check("abort_cnt", {pass1, fail1, fs1}, {8'd40, 8'd0, 1'b0});
    check("abort_hold", {enc1, flt1}, 7'd40);
    @(negedge clk);
    check("abort_idle", {busy1, done1, pass1}, {1'b0, 1'b0, 8'd40});
    run("post_abort", 0, 128, 0, 1'b0, 4'h0, 3'd0);

    // start held high through APPLY must not restart; reset at v=70 clears everything.
    @(negedge clk); start = 1'b1;
    wait_vec("rst", 7'd70);
    check("rst_pre", {busy1, pass1}, {1'b1, 8'd70});
    rst_n = 1'b0;
    @(negedge clk);
    check_zero("midrst");
    rst_n = 1'b1; abort = 1'b1;
    repeat (3) @(negedge clk);
    check("abort_blk1", {busy1, done1, enc1, flt1}, 9'd0);
    check("abort_blk0", {busy0, done0, enc0, flt0}, 9'd0);
    abort = 1'b0; start = 1'b0;

    run("post_rst", 0, 128, 0, 1'b0, 4'h0, 3'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
